// File: rtl/par_fill_pkg.sv
// Shared types and helpers for the parallel memory fill engine.
package par_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        FILL_CONST = 1'b0,
        FILL_RAMP  = 1'b1
    } mode_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/par_done_collector.sv
// Sticky per-channel done bits; all_done also sees this cycle's mem_done.
module par_done_collector #(
    parameter int N_CHAN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              capture,
    input  logic [N_CHAN-1:0] mask,
    input  logic [N_CHAN-1:0] mem_done,
    output logic              all_done
);

    logic [N_CHAN-1:0] collected;

    // Disabled channels are pre-set so they never hold up completion
    always_ff @(posedge clk) begin
        if (reset) begin
            collected <= '0;
        end else if (load) begin
            collected <= ~mask;
        end else if (capture) begin
            collected <= collected | mem_done;
        end
    end

    assign all_done = &(collected | mem_done);

endmodule

// File: rtl/par_mem_fill.sv
// Lockstep fill of N_CHAN memories, addresses 0..DEPTH-1.
// Define PAR_FILL_TIMEOUT_EN to enable the per-address watchdog.
module par_mem_fill
    import par_fill_pkg::*;
#(
    parameter int N_CHAN         = 3,
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = clog2_min1(DEPTH),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     mode,
    input  logic [WIDTH-1:0]         fill_value,
    input  logic [N_CHAN-1:0]        chan_en,
    output logic [N_CHAN*ADDR_W-1:0] mem_addr0,
    output logic [N_CHAN*WIDTH-1:0]  mem_write_data,
    output logic [N_CHAN-1:0]        mem_write_en,
    input  logic [N_CHAN-1:0]        mem_done,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    mode_e             mode_q;
    logic [WIDTH-1:0]  fill_q;
    logic [N_CHAN-1:0] chan_en_q;

    logic              all_done;
    logic              go_start;
    logic              complete;
    logic              last;
    logic              timeout;
    logic              coll_load;
    logic [N_CHAN-1:0] coll_mask;
    logic [WIDTH-1:0]  data;

    assign go_start = (state == ST_IDLE) && go;
    assign complete = (state == ST_WAIT) && all_done;
    assign last     = (addr == LAST_ADDR);

`ifdef PAR_FILL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt;
    logic          err_q;

    assign timeout = (state == ST_WAIT) && !all_done &&
                     (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != ST_WAIT) begin
                wd_cnt <= '0;
            end else if (!all_done) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign coll_load = go_start || (complete && !last);
    assign coll_mask = go_start ? chan_en : chan_en_q;

    par_done_collector #(
        .N_CHAN (N_CHAN)
    ) u_collector (
        .clk      (clk),
        .reset    (reset),
        .load     (coll_load),
        .capture  ((state == ST_ISSUE) || (state == ST_WAIT)),
        .mask     (coll_mask),
        .mem_done (mem_done),
        .all_done (all_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            mode_q    <= FILL_CONST;
            fill_q    <= '0;
            chan_en_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        mode_q    <= mode_e'(mode);
                        fill_q    <= fill_value;
                        chan_en_q <= chan_en;
                        addr      <= '0;
                        state     <= (chan_en == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (complete) begin
                        if (last) begin
                            state <= ST_DONE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end else if (timeout) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_ISSUE) || (state == ST_WAIT);
    assign done = (state == ST_DONE);

    assign data = (mode_q == FILL_RAMP) ? fill_q + WIDTH'(addr) : fill_q;

    always_comb begin
        mem_addr0      = '0;
        mem_write_data = '0;
        mem_write_en   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            mem_addr0[i*ADDR_W +: ADDR_W] = addr;
            if (state == ST_ISSUE) begin
                mem_write_data[i*WIDTH +: WIDTH] = data;
                mem_write_en[i]                  = chan_en_q[i];
            end
        end
    end

endmodule

// File: tb/tb_par_mem_fill.sv
// Directed bench for par_mem_fill with per-channel done-latency memory models.
module tb_par_mem_fill;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            go;
    logic            mode;
    logic [W-1:0]    fill_value;
    logic [N-1:0]    chan_en;
    logic [N*AW-1:0] mem_addr0;
    logic [N*W-1:0]  mem_write_data;
    logic [N-1:0]    mem_write_en;
    logic [N-1:0]    mem_done;
    logic            busy;
    logic            done;
    logic            err;

    int n_vec = 0;
    int n_err = 0;

    int           lat    [N];
    int           pend   [N];
    int           wr_cnt [N];
    int           overlap;
    logic [W-1:0] mem    [N][D];

    always #5 clk = ~clk;

    par_mem_fill #(
        .N_CHAN         (N),
        .WIDTH          (W),
        .DEPTH          (D),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .mode           (mode),
        .fill_value     (fill_value),
        .chan_en        (chan_en),
        .mem_addr0      (mem_addr0),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_done       (mem_done),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Memory model: latency 0 means the channel never answers
    always @(posedge clk) begin
        if (go) begin
            overlap = 0;
            for (int i = 0; i < N; i++) begin
                wr_cnt[i] = 0;
                for (int a = 0; a < D; a++) mem[i][a] = 32'hDEAD_BEEF;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                pend[i] <= 0;
            end else if (mem_write_en[i]) begin
                mem[i][mem_addr0[i*AW +: AW]] = mem_write_data[i*W +: W];
                wr_cnt[i] = wr_cnt[i] + 1;
                for (int j = 0; j < N; j++)
                    if (pend[j] != 0) overlap = overlap + 1;
                pend[i] <= lat[i];
            end else if (pend[i] != 0) begin
                pend[i] <= pend[i] - 1;
            end
        end
    end

    always_comb begin
        mem_done = '0;
        for (int i = 0; i < N; i++) mem_done[i] = (pend[i] == 1);
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_fill(input logic m, input logic [W-1:0] f,
                            input logic [N-1:0] en, output int dc);
        @(negedge clk);
        go         = 1'b1;
        mode       = m;
        fill_value = f;
        chan_en    = en;
        @(posedge clk);
        #1;
        go = 1'b0;
        dc = -1;
        for (int k = 1; k <= 200; k++) begin
            if (done) begin
                dc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (dc > 0) begin
            @(posedge clk);
            #1;
            check("done_pulse", {63'd0, done}, 64'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [W-1:0] ramp_exp [D];
    int dc;
    int ndone;

    initial begin
        reset      = 1'b1;
        go         = 1'b0;
        mode       = 1'b0;
        fill_value = '0;
        chan_en    = '0;
        overlap    = 0;
        for (int i = 0; i < N; i++) begin
            lat[i]    = 1;
            wr_cnt[i] = 0;
        end
        ramp_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

        do_reset();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_we", {61'd0, mem_write_en}, 64'd0);
        check("rst_addr", {58'd0, mem_addr0}, 64'd0);
        check("rst_data", mem_write_data[63:0], 64'd0);

        run_fill(1'b0, 32'hA5, 3'b111, dc);
        check("const_done_cyc", dc, 9);
        check("const_addr_hold", {62'd0, mem_addr0[AW-1:0]}, 64'd3);
        check("const_data_idle", mem_write_data[63:0], 64'd0);
        for (int i = 0; i < N; i++) begin
            check("const_wr_cnt", wr_cnt[i], 4);
            for (int a = 0; a < D; a++)
                check("const_data", mem[i][a], 64'hA5);
        end

        run_fill(1'b1, 32'hFFFF_FFFE, 3'b111, dc);
        check("ramp_done_cyc", dc, 9);
        for (int i = 0; i < N; i++)
            for (int a = 0; a < D; a++)
                check("ramp_data", mem[i][a], ramp_exp[a]);

        run_fill(1'b0, 32'h1234_5678, 3'b101, dc);
        check("mask_done_cyc", dc, 9);
        check("mask_ch1_wr", wr_cnt[1], 0);
        check("mask_ch0_wr", wr_cnt[0], 4);
        check("mask_ch1_mem", mem[1][2], 64'hDEAD_BEEF);
        check("mask_ch2_mem", mem[2][3], 64'h1234_5678);

        run_fill(1'b0, 32'h55, 3'b000, dc);
        check("none_done_cyc", dc, 1);
        check("none_wr", wr_cnt[0] + wr_cnt[1] + wr_cnt[2], 0);

        lat = '{1, 5, 3};
        run_fill(1'b1, 32'h100, 3'b111, dc);
        check("skew_done_cyc", dc, 25);
        check("skew_overlap", overlap, 0);
        for (int i = 0; i < N; i++)
            for (int a = 0; a < D; a++)
                check("skew_data", mem[i][a], 64'h100 + 64'(a));
        lat = '{1, 1, 1};

        @(negedge clk);
        go         = 1'b1;
        mode       = 1'b0;
        fill_value = 32'h33;
        chan_en    = 3'b111;
        @(posedge clk);
        #1;
        go = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk);
            #1;
        end
        check("mid_addr", {62'd0, mem_addr0[AW-1:0]}, 64'd2);
        check("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_we", {61'd0, mem_write_en}, 64'd0);
        check("abort_addr", {58'd0, mem_addr0}, 64'd0);
        check("abort_data", mem_write_data[63:0], 64'd0);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        run_fill(1'b0, 32'h77, 3'b111, dc);
        check("restart_done_cyc", dc, 9);
        check("restart_addr0", mem[0][0], 64'h77);
        check("restart_addr3", mem[2][3], 64'h77);

`ifdef PAR_FILL_TIMEOUT_EN
        lat = '{1, 1, 0};
        run_fill(1'b0, 32'h99, 3'b111, dc);
        check("to_done_cyc", dc, 10);
        check("to_err", {63'd0, err}, 64'd1);
        check("to_skipped", wr_cnt[0], 1);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("to_single_done", ndone, 0);
        check("to_err_sticky", {63'd0, err}, 64'd1);
        lat = '{1, 1, 1};
        do_reset();
        check("to_err_clr", {63'd0, err}, 64'd0);
`else
        check("err_tied", {63'd0, err}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
